// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The master side is the datapath; the slave side is the sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_branch_taken;
  logic [63:0]      mem_branch_target;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_write;
  logic             exmem_flush;
  logic             pc_redirect;
  logic [63:0]      redirect_target;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
           mem_branch_taken, mem_branch_target, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, exmem_flush, pc_redirect, redirect_target,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
           mem_branch_taken, mem_branch_target, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, exmem_flush, pc_redirect, redirect_target,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot flush, load-use stalls,
// memory-wait freeze with deferred branch redirect, and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic             pend_q, pend_d;
  logic [63:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic        load_use_s;
  logic        pc_write_s, ifid_write_s, ifid_flush_s;
  logic        idex_write_s, idex_bubble_s;
  logic        exmem_write_s, exmem_flush_s;
  logic        pc_redirect_s;
  logic [63:0] redirect_target_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Load-use hazard between the ID/EX load and the IF/ID consumer
  always_comb begin
    load_use_s = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                 ((hz.ex_rd == hz.id_rs1) || (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));
  end

  // Next-state and Mealy control outputs
  always_comb begin
    state_d           = state_q;
    boot_cnt_d        = boot_cnt_q;
    pend_d            = pend_q;
    pend_tgt_d        = pend_tgt_q;
    pc_write_s        = 1'b1;
    ifid_write_s      = 1'b1;
    ifid_flush_s      = 1'b0;
    idex_write_s      = 1'b1;
    idex_bubble_s     = 1'b0;
    exmem_write_s     = 1'b1;
    exmem_flush_s     = 1'b0;
    pc_redirect_s     = 1'b0;
    redirect_target_s = 64'd0;

    case (state_q)
      ST_BOOT: begin
        pc_write_s    = 1'b0;
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
        exmem_flush_s = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BW'(1);
        end
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (hz.mem_busy) begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          idex_write_s  = 1'b0;
          exmem_write_s = 1'b0;
          state_d       = ST_MEM_WAIT;
          if (hz.mem_branch_taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = hz.mem_branch_target;
          end else begin
            pend_d     = pend_q;
          end
        end else begin
          state_d = ST_RUN;
          // A redirect captured during the freeze takes precedence on the first free cycle
          if (pend_q) begin
            pc_redirect_s     = 1'b1;
            redirect_target_s = pend_tgt_q;
            ifid_flush_s      = 1'b1;
            idex_bubble_s     = 1'b1;
            exmem_flush_s     = 1'b1;
            pend_d            = 1'b0;
          end else if (hz.mem_branch_taken) begin
            pc_redirect_s     = 1'b1;
            redirect_target_s = hz.mem_branch_target;
            ifid_flush_s      = 1'b1;
            idex_bubble_s     = 1'b1;
            exmem_flush_s     = 1'b1;
          end else if (load_use_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
          end else begin
            pc_write_s    = 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_BOOT;
        boot_cnt_d = '0;
        pend_d     = 1'b0;
      end
    endcase

    stall_cnt_d = sat_inc(stall_cnt_q, (state_q != ST_BOOT) && !pc_write_s);
    flush_cnt_d = sat_inc(flush_cnt_q, pc_redirect_s);
  end

  // State, pending redirect and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 64'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_write        = pc_write_s;
  assign hz.ifid_write      = ifid_write_s;
  assign hz.ifid_flush      = ifid_flush_s;
  assign hz.idex_write      = idex_write_s;
  assign hz.idex_bubble     = idex_bubble_s;
  assign hz.exmem_write     = exmem_write_s;
  assign hz.exmem_flush     = exmem_flush_s;
  assign hz.pc_redirect     = pc_redirect_s;
  assign hz.redirect_target = redirect_target_s;
  assign hz.stall_cnt       = stall_cnt_q;
  assign hz.flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a 32-bit-counter and a 4-bit-counter
// instance receive identical stimulus so counter saturation can be checked.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) hz_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  hz_b ();

  pipeline_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .hz(hz_a));
  pipeline_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .hz(hz_b));

  // Control vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_flush
  localparam logic [6:0] V_NORM   = 7'b1101010;
  localparam logic [6:0] V_BOOT   = 7'b0111111;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_LU     = 7'b0001110;
  localparam logic [6:0] V_REDIR  = 7'b1111111;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rd_en, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic use2, input logic taken,
                        input logic [63:0] tgt, input logic busy);
    hz_a.ex_mem_read = rd_en;  hz_b.ex_mem_read = rd_en;
    hz_a.ex_rd = rd;           hz_b.ex_rd = rd;
    hz_a.id_rs1 = rs1;         hz_b.id_rs1 = rs1;
    hz_a.id_rs2 = rs2;         hz_b.id_rs2 = rs2;
    hz_a.id_uses_rs2 = use2;   hz_b.id_uses_rs2 = use2;
    hz_a.mem_branch_taken = taken;   hz_b.mem_branch_taken = taken;
    hz_a.mem_branch_target = tgt;    hz_b.mem_branch_target = tgt;
    hz_a.mem_busy = busy;      hz_b.mem_busy = busy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic [6:0] vec, input logic redir,
                          input logic [63:0] tgt);
    #2;
    chk({tag, ".ctrl"}, {57'd0, hz_a.pc_write, hz_a.ifid_write, hz_a.ifid_flush, hz_a.idex_write,
                         hz_a.idex_bubble, hz_a.exmem_write, hz_a.exmem_flush}, {57'd0, vec});
    chk({tag, ".redir"}, {63'd0, hz_a.pc_redirect}, {63'd0, redir});
    chk({tag, ".tgt"}, hz_a.redirect_target, tgt);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] st, input logic [31:0] fl);
    chk({tag, ".stall"}, {32'd0, hz_a.stall_cnt}, {32'd0, st});
    chk({tag, ".flush"}, {32'd0, hz_a.flush_cnt}, {32'd0, fl});
  endtask

  initial begin
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    #3;
    chk_ctrl("in_reset", V_BOOT, 1'b0, 64'd0);
    chk_cnt("in_reset", 32'd0, 32'd0);

    // Boot flush: exactly two cycles after release
    step(); reset = 1'b0;
    chk_ctrl("boot1", V_BOOT, 1'b0, 64'd0);
    step(); chk_ctrl("boot2", V_BOOT, 1'b0, 64'd0);
    step(); chk_ctrl("run0", V_NORM, 1'b0, 64'd0);
    chk_cnt("run0", 32'd0, 32'd0);

    // Load-use on rs1
    step(); set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk_ctrl("lu_rs1", V_LU, 1'b0, 64'd0);
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk_ctrl("lu_after", V_NORM, 1'b0, 64'd0);
    chk_cnt("lu_after", 32'd1, 32'd0);

    // x0 destination never stalls
    step(); set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk_ctrl("lu_x0", V_NORM, 1'b0, 64'd0);
    // rs2 match ignored when rs2 unused, honoured when used
    step(); set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 64'd0, 1'b0);
    chk_ctrl("lu_rs2_unused", V_NORM, 1'b0, 64'd0);
    step(); set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 64'd0, 1'b0);
    chk_ctrl("lu_rs2_used", V_LU, 1'b0, 64'd0);
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk_cnt("lu_rs2_after", 32'd2, 32'd0);

    // Branch redirect overrides a simultaneous load-use
    step(); set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 64'h1000, 1'b0);
    chk_ctrl("br", V_REDIR, 1'b1, 64'h1000);
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk_ctrl("br_after", V_NORM, 1'b0, 64'd0);
    chk_cnt("br_after", 32'd2, 32'd1);

    // Three-cycle memory freeze
    for (int i = 0; i < 3; i++) begin
      step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b1);
      chk_ctrl("busy", V_FREEZE, 1'b0, 64'd0);
    end
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk_ctrl("busy_done", V_NORM, 1'b0, 64'd0);
    chk_cnt("busy_done", 32'd5, 32'd1);

    // Branches during freeze: last target wins, single redirect afterwards
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 64'h2000, 1'b1);
    chk_ctrl("pend1", V_FREEZE, 1'b0, 64'd0);
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 64'h3000, 1'b1);
    chk_ctrl("pend2", V_FREEZE, 1'b0, 64'd0);
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b1);
    chk_ctrl("pend3", V_FREEZE, 1'b0, 64'd0);
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk_ctrl("pend_redir", V_REDIR, 1'b1, 64'h3000);
    step(); chk_ctrl("pend_after", V_NORM, 1'b0, 64'd0);
    chk_cnt("pend_after", 32'd8, 32'd2);
    chk("b_stall8", {60'd0, hz_b.stall_cnt}, 64'd8);

    // Reset while frozen with a pending redirect
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 64'h4000, 1'b1);
    chk_ctrl("rst_pend", V_FREEZE, 1'b0, 64'd0);
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b1);
    reset = 1'b1;
    chk_ctrl("rst_mid", V_BOOT, 1'b0, 64'd0);
    chk_cnt("rst_mid", 32'd0, 32'd0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    step(); reset = 1'b0;
    chk_ctrl("reboot1", V_BOOT, 1'b0, 64'd0);
    step(); chk_ctrl("reboot2", V_BOOT, 1'b0, 64'd0);
    step(); chk_ctrl("reboot_run", V_NORM, 1'b0, 64'd0);
    step(); chk_ctrl("reboot_run2", V_NORM, 1'b0, 64'd0);
    chk_cnt("reboot_run2", 32'd0, 32'd0);

    // Twenty load-use stalls: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      step(); set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
      chk_ctrl("sat_lu", V_LU, 1'b0, 64'd0);
    end
    step(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    #2;
    chk("a_stall20", {32'd0, hz_a.stall_cnt}, 64'd20);
    chk("b_stall_sat", {60'd0, hz_b.stall_cnt}, 64'd15);
    chk("b_flush0", {60'd0, hz_b.flush_cnt}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
